// File: rtl/cpu_boot_pkg.sv
// rtl/cpu_boot_pkg.sv - shared types and constants for the CPU boot controller
package cpu_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_HALTED  = 3'd4,
        ST_TIMEOUT = 3'd5
    } boot_state_t;

    localparam int DEF_HALT_CYCLES = 4;

    // Halt idiom is "beq rs,rs,-1": the CPU branches onto itself forever.
    localparam logic [5:0] OP_BEQ = 6'b000100;

    function automatic logic [31:0] halt_word(input logic [4:0] rs);
        return {OP_BEQ, rs, rs, 16'hFFFF};
    endfunction

endpackage

// File: rtl/cpu_halt_detect.sv
// rtl/cpu_halt_detect.sv - flags a CPU whose PC has stopped moving
module cpu_halt_detect
    import cpu_boot_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int HALT_CYCLES = DEF_HALT_CYCLES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              halt
);

    localparam int SW = $clog2(HALT_CYCLES + 1);

    logic [ADDR_W-1:0] pc_q;
    logic              pc_vld;
    logic [SW-1:0]     stall_cnt;
    logic              same;

    // The first RUN cycle only captures the PC, so a freshly reset PC never
    // counts as a repeat of a stale value.
    assign same = pc_vld && (cpu_pc == pc_q);
    assign halt = run && same && (stall_cnt == SW'(HALT_CYCLES - 1));

    // Track previous PC and the run of consecutive equal samples while running
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q      <= '0;
            pc_vld    <= 1'b0;
            stall_cnt <= '0;
        end else if (!run) begin
            pc_q      <= '0;
            pc_vld    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            pc_q      <= cpu_pc;
            pc_vld    <= 1'b1;
            stall_cnt <= same ? stall_cnt + SW'(1) : '0;
        end
    end

endmodule

// File: rtl/cpu_boot_ctrl.sv
// rtl/cpu_boot_ctrl.sv - program loader and run controller; LOAD_CHECKSUM_EN adds load_sum
module cpu_boot_ctrl
    import cpu_boot_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int HALT_CYCLES = DEF_HALT_CYCLES,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic [CNT_W-1:0]  run_limit,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic              load_err,
    output logic [ADDR_W:0]   prog_len,
    output logic [CNT_W-1:0]  cycle_count
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] load_sum
`endif
);

    boot_state_t       state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  limit_q;
    logic              xfer;
    logic              at_end;
    logic              start;
    logic              halt;
    logic              timeout_hit;

    assign xfer        = load_valid && (state_q == ST_LOAD);
    assign at_end      = (wr_ptr == {ADDR_W{1'b1}});
    assign timeout_hit = (limit_q != '0) && (cycle_count == limit_q - CNT_W'(1));
    assign imem_we     = xfer;
    assign imem_addr   = wr_ptr;
    assign imem_wdata  = load_data;

    cpu_halt_detect #(
        .ADDR_W      (ADDR_W),
        .HALT_CYCLES (HALT_CYCLES)
    ) u_halt (
        .clock  (clock),
        .reset  (reset),
        .run    (state_q == ST_RUN),
        .cpu_pc (cpu_pc),
        .halt   (halt)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state and state-decoded control outputs
    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        cpu_reset  = 1'b1;
        busy       = 1'b0;
        start      = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
                // A halted CPU keeps spinning so its register file stays readable.
                cpu_reset = (state_q != ST_HALTED);
                if (go) begin
                    start   = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                busy       = 1'b1;
                if (xfer && (load_last || at_end)) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                busy    = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                busy      = 1'b1;
                cpu_reset = 1'b0;
                if (halt)             state_d = ST_HALTED;
                else if (timeout_hit) state_d = ST_TIMEOUT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Load pointer, flags and run counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            prog_len    <= '0;
            cycle_count <= '0;
            limit_q     <= '0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            load_err    <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            load_sum    <= '0;
`endif
        end else begin
            if (start) begin
                wr_ptr      <= '0;
                prog_len    <= '0;
                cycle_count <= '0;
                limit_q     <= run_limit;
                done        <= 1'b0;
                timed_out   <= 1'b0;
                load_err    <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
                load_sum    <= '0;
`endif
            end
            if (xfer) begin
                // The pointer parks on the last word instead of wrapping.
                if (!at_end) wr_ptr <= wr_ptr + ADDR_W'(1);
                prog_len <= prog_len + (ADDR_W + 1)'(1);
                load_err <= at_end && !load_last;
`ifdef LOAD_CHECKSUM_EN
                load_sum <= load_sum + load_data;
`endif
            end
            if (state_q == ST_RUN) begin
                // Count only cycles that stay in RUN, so the exit cycle is the final value.
                if (state_d == ST_RUN && cycle_count != '1) cycle_count <= cycle_count + CNT_W'(1);
                if (halt)             done      <= 1'b1;
                else if (timeout_hit) timed_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// tb/tb_cpu_boot_ctrl.sv - self-checking bench for cpu_boot_ctrl
module tb_cpu_boot_ctrl;
    import cpu_boot_pkg::*;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int HC = 4;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          go = 1'b0;
    logic [CW-1:0] run_limit = '0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [DW-1:0] load_data = '0;
    logic          load_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          cpu_reset;
    logic [AW-1:0] cpu_pc = '0;
    logic          busy, done, timed_out, load_err;
    logic [AW:0]   prog_len;
    logic [CW-1:0] cycle_count;
`ifdef LOAD_CHECKSUM_EN
    logic [DW-1:0] load_sum;
`endif

    cpu_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .HALT_CYCLES(HC), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .go(go), .run_limit(run_limit),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .load_last(load_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .cpu_pc(cpu_pc),
        .busy(busy), .done(done), .timed_out(timed_out), .load_err(load_err),
        .prog_len(prog_len), .cycle_count(cycle_count)
`ifdef LOAD_CHECKSUM_EN
        , .load_sum(load_sum)
`endif
    );

    always #5 clock = ~clock;

    int            checks = 0;
    int            errors = 0;
    int            wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    logic [DW-1:0] prog[$];
    int            pc_seq[$];
    int            pc_idx = 0;
    bit            rst_seen = 1'b1;

    function automatic int seq_at(input int i);
        if (pc_seq.size() == 0) return 0;
        return (i < pc_seq.size()) ? pc_seq[i] : pc_seq[pc_seq.size() - 1];
    endfunction

    // Reference: first RUN cycle whose PC equals each of the previous HC PCs.
    function automatic int model_halt_k();
        for (int k = HC; k < 2000; k++) begin
            bit ok = 1'b1;
            for (int j = 1; j <= HC; j++) if (seq_at(k - j) != seq_at(k)) ok = 1'b0;
            if (ok) return k;
        end
        return -1;
    endfunction

    // Write log of the imem port
    always @(negedge clock) begin
        if (imem_we) begin
            wr_addr_q.push_back(int'(imem_addr));
            wr_data_q.push_back(imem_wdata);
        end
        rst_seen = cpu_reset;
    end

    // Fake CPU: PC restarts at the head of pc_seq while held in reset, then steps along it
    always @(posedge clock) begin
        #1;
        if (rst_seen) pc_idx = 0;
        else          pc_idx = pc_idx + 1;
        cpu_pc = AW'(seq_at(pc_idx));
    end

    task automatic do_go(input int limit);
        @(posedge clock); #2;
        go = 1'b1;
        run_limit = CW'(limit);
        @(posedge clock); #2;
        go = 1'b0;
    endtask

    task automatic load_words(input bit use_last, input bit toggle, output int accepted);
        int guard = 0;
        accepted = 0;
        while (accepted < prog.size() && guard < 100) begin
            load_valid = toggle ? ((guard % 2) == 0) : 1'b1;
            load_data  = prog[accepted];
            load_last  = use_last && (accepted == prog.size() - 1);
            @(negedge clock);
            if (!load_ready) break;
            if (load_valid) accepted++;
            guard++;
            @(posedge clock); #2;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge clock); #2;
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s wait: busy got 1 exp 0 after %0d cycles", name, n);
        end
    endtask

    task automatic make_prog(input int n, input bit with_halt);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back($urandom);
        if (with_halt) prog[n - 1] = halt_word(5'd8);
    endtask

    task automatic make_fib_pcs(input int loops);
        pc_seq.delete();
        for (int i = 0; i < 4; i++) pc_seq.push_back(i);
        for (int l = 0; l < loops; l++) for (int i = 4; i < 10; i++) pc_seq.push_back(i);
        pc_seq.push_back(10);
        pc_seq.push_back(11);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if ({cpu_reset, busy, load_ready, imem_we, done, timed_out, load_err} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset flags got %b exp 1000000",
                     {cpu_reset, busy, load_ready, imem_we, done, timed_out, load_err});
        end
        reset = 1'b1;
        @(posedge clock); #2;
        checks++;
        if (prog_len !== '0 || cycle_count !== '0 || imem_addr !== '0 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset values got len=%0d cnt=%0d addr=%0d crst=%b exp 0 0 0 1",
                     prog_len, cycle_count, imem_addr, cpu_reset);
        end
    endtask

    task automatic test_fib();
        int acc, base, k, bad;
        make_prog(12, 1'b1);
        make_fib_pcs($urandom_range(3, 6));
        k = model_halt_k();
        base = wr_addr_q.size();
        do_go(0);
        load_words(1'b1, 1'b0, acc);
        wait_idle("fib");
        checks++;
        if (acc != 12 || prog_len !== 5'd12) begin
            errors++;
            $display("FAIL fib len got acc=%0d prog_len=%0d exp 12", acc, prog_len);
        end
        bad = (wr_addr_q.size() - base != 12);
        for (int i = 0; i < 12 && !bad; i++)
            if (wr_addr_q[base + i] != i || wr_data_q[base + i] !== prog[i]) bad = 1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL fib writes got %0d writes exp 12 in-order matching words", wr_addr_q.size() - base);
        end
        checks++;
        if ({done, timed_out, cpu_reset, load_err} !== 4'b1000) begin
            errors++;
            $display("FAIL fib flags got done/to/crst/err=%b exp 1000", {done, timed_out, cpu_reset, load_err});
        end
        checks++;
        if (cycle_count !== CW'(k)) begin
            errors++;
            $display("FAIL fib cycle_count got %0d exp %0d", cycle_count, k);
        end
    endtask

    task automatic test_timeout();
        int acc;
        make_fib_pcs(5);
        do_go(20);
        load_words(1'b1, 1'b0, acc);
        repeat (5) @(posedge clock);
        #2;
        go = 1'b1;
        @(posedge clock); #2;
        go = 1'b0;
        checks++;
        if (busy !== 1'b1 || cpu_reset !== 1'b0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL go_ignored got busy=%b crst=%b rdy=%b exp 1 0 0", busy, cpu_reset, load_ready);
        end
        wait_idle("timeout");
        checks++;
        if ({done, timed_out, cpu_reset} !== 3'b011 || cycle_count !== CW'(19)) begin
            errors++;
            $display("FAIL timeout got done/to/crst=%b cnt=%0d exp 011 19", {done, timed_out, cpu_reset}, cycle_count);
        end
    endtask

    task automatic test_limit_boundary();
        int acc, k;
        make_fib_pcs($urandom_range(1, 3));
        k = model_halt_k();
        for (int d = 0; d < 2; d++) begin
            do_go(k + 1 - d);
            load_words(1'b1, 1'b0, acc);
            wait_idle("limit");
            checks++;
            if (d == 0 && ({done, timed_out} !== 2'b10 || cycle_count !== CW'(k))) begin
                errors++;
                $display("FAIL same_edge got done/to=%b cnt=%0d exp 10 %0d", {done, timed_out}, cycle_count, k);
            end else if (d == 1 && ({done, timed_out} !== 2'b01 || cycle_count !== CW'(k - 1))) begin
                errors++;
                $display("FAIL early_timeout got done/to=%b cnt=%0d exp 01 %0d", {done, timed_out}, cycle_count, k - 1);
            end
        end
    endtask

    task automatic test_overflow();
        int acc, base, bad;
        pc_seq = '{0, 1, 2};
        for (int e = 0; e < 2; e++) begin
            make_prog(e == 0 ? 17 : 16, 1'b0);
            base = wr_addr_q.size();
            do_go(0);
            load_words(e == 1, 1'b0, acc);
            bad = (acc != 16) || (wr_addr_q.size() - base != 16);
            for (int i = 0; i < 16 && !bad; i++)
                if (wr_addr_q[base + i] != i || wr_data_q[base + i] !== prog[i]) bad = 1;
            checks++;
            if (bad || prog_len !== 5'd16) begin
                errors++;
                $display("FAIL overflow%0d writes got acc=%0d len=%0d exp 16 writes to 0..15", e, acc, prog_len);
            end
            checks++;
            if (load_err !== (e == 0)) begin
                errors++;
                $display("FAIL overflow%0d load_err got %b exp %b", e, load_err, e == 0);
            end
            wait_idle("overflow");
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL overflow%0d run got done=%b exp 1", e, done);
            end
        end
    endtask

    task automatic test_toggle();
        int acc, base, n, bad;
        pc_seq = '{0, 1, 1};
        for (int r = 0; r < 3; r++) begin
            n = (r == 0) ? 1 : $urandom_range(3, 10);
            make_prog(n, 1'b0);
            base = wr_addr_q.size();
            do_go(0);
            load_words(1'b1, r != 0, acc);
            bad = (acc != n) || (wr_addr_q.size() - base != n);
            for (int i = 0; i < n && !bad; i++)
                if (wr_addr_q[base + i] != i || wr_data_q[base + i] !== prog[i]) bad = 1;
            checks++;
            if (bad || prog_len !== 5'(n)) begin
                errors++;
                $display("FAIL toggle n=%0d got acc=%0d len=%0d exp contiguous 0..%0d", n, acc, prog_len, n - 1);
            end
            wait_idle("toggle");
        end
    endtask

    task automatic test_async_reset();
        int acc, base;
        make_prog(5, 1'b0);
        pc_seq = '{0, 1, 2, 2};
        do_go(0);
        load_words(1'b0, 1'b0, acc);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({cpu_reset, busy, load_ready, done, timed_out, load_err} !== 6'b100000 || prog_len !== '0) begin
            errors++;
            $display("FAIL async_reset got flags=%b len=%0d exp 100000 0",
                     {cpu_reset, busy, load_ready, done, timed_out, load_err}, prog_len);
        end
        @(negedge clock);
        reset = 1'b1;
        make_prog(3, 1'b0);
        base = wr_addr_q.size();
        do_go(0);
        load_words(1'b1, 1'b0, acc);
        checks++;
        if (wr_addr_q.size() - base != 3 || wr_addr_q[base] != 0 || prog_len !== 5'd3) begin
            errors++;
            $display("FAIL reload got %0d writes first_addr=%0d len=%0d exp 3 0 3",
                     wr_addr_q.size() - base, wr_addr_q[base], prog_len);
        end
        wait_idle("reload");
    endtask

`ifdef LOAD_CHECKSUM_EN
    task automatic test_checksum();
        int acc;
        logic [DW-1:0] sum;
        pc_seq = '{0, 0};
        prog = '{32'd1, 32'd2, 32'hFFFF_FFFF};
        do_go(0);
        load_words(1'b1, 1'b0, acc);
        checks++;
        if (load_sum !== 32'd2) begin
            errors++;
            $display("FAIL checksum got %h exp 00000002", load_sum);
        end
        wait_idle("checksum");
        make_prog($urandom_range(2, 9), 1'b0);
        sum = '0;
        foreach (prog[i]) sum += prog[i];
        do_go(0);
        checks++;
        if (load_sum !== '0) begin
            errors++;
            $display("FAIL checksum_clear got %h exp 0", load_sum);
        end
        load_words(1'b1, 1'b0, acc);
        checks++;
        if (load_sum !== sum) begin
            errors++;
            $display("FAIL checksum_rand got %h exp %h", load_sum, sum);
        end
        wait_idle("checksum2");
    endtask
`endif

    initial begin
        test_reset();
        test_fib();
        test_timeout();
        test_limit_boundary();
        test_overflow();
        test_toggle();
        test_async_reset();
`ifdef LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
